branch_pred_unit: RTL and testbench

- Decode-stage next-PC selector for the pipelined MIPS core, with a table of 2-bit saturating branch predictors.
- Indexed by PC: read in F, updated in D when a conditional branch resolves.
- Produces `PCSrc_D` from `nPC_Sel` and the comparator result.
- Flags mispredictions so the hazard unit can flush the F/D register and redirect fetch.

---
 rtl/branch_pred_unit.sv | 157 +++++++++++++++
 tb/tb_branch_pred_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_pred_unit.sv
// -----------------------------------------------------------------------------
// branch_pred_unit
//
// Decode-stage next-PC selector for the pipelined MIPS core, paired with a
// table of 2-bit saturating branch predictors.
//
//   * The table is read in F, indexed by pc_f, and gives pred_taken_f.
//   * The table is written in D when a conditional branch resolves, indexed
//     by pc_d.
//   * PCSrc_D is derived from nPC_Sel and the D-stage comparator (bmove).
//   * mispredict_d tells the hazard unit to flush F/D and redirect fetch.
//
// Parameters
//   IDX_W        predictor index width (table depth 2**IDX_W)
//   CNT_W        statistics counter width (stats build only)
//
// Ports
//   clk          single clock
//   reset        asynchronous, active-high reset
//   pc_f         fetch-stage PC
//   pred_taken_f prediction for pc_f (MSB of the indexed counter)
//   valid_d      D-stage instruction is valid (not a bubble)
//   stall_d      D stage frozen this cycle
//   pc_d         D-stage PC
//   pred_d       prediction carried with the instruction through F/D
//   nPC_Sel      00 seq, 01 cond branch, 10 jump imm, 11 jump reg
//   bmove        branch condition true
//   PCSrc_D      00 PC+4, 01 branch target, 10 jump imm, 11 jump reg
//   mispredict_d resolved branch outcome differs from pred_d
//   br_cnt       resolved conditional branches   (BPRED_STATS_EN only)
//   miss_cnt     mispredicted branches           (BPRED_STATS_EN only)
//
// Build option
//   BPRED_STATS_EN  when defined, adds br_cnt/miss_cnt saturating counters.
// -----------------------------------------------------------------------------
module branch_pred_unit #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       pc_f,
   output logic              pred_taken_f,
   input  logic              valid_d,
   input  logic              stall_d,
   input  logic [31:0]       pc_d,
   input  logic              pred_d,
   input  logic [1:0]        nPC_Sel,
   input  logic              bmove,
   output logic [1:0]        PCSrc_D,
   output logic              mispredict_d
`ifdef BPRED_STATS_EN
   ,
   output logic [CNT_W-1:0]  br_cnt,
   output logic [CNT_W-1:0]  miss_cnt
`endif
);

   localparam int DEPTH = 2 ** IDX_W;

   localparam logic [1:0] SEL_SEQ    = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_JIMM   = 2'b10;
   localparam logic [1:0] SEL_JREG   = 2'b11;

   localparam logic [1:0] SRC_PC4    = 2'b00;
   localparam logic [1:0] SRC_BTGT   = 2'b01;
   localparam logic [1:0] SRC_JIMM   = 2'b10;
   localparam logic [1:0] SRC_JREG   = 2'b11;

   localparam logic [1:0] CNT_SNT    = 2'b00;
   localparam logic [1:0] CNT_WNT    = 2'b01;
   localparam logic [1:0] CNT_ST     = 2'b11;

   logic [1:0]       table_q [DEPTH];
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] wr_idx;
   logic             is_branch;
   logic             upd;

   // Word-aligned PCs: bits [1:0] never carry index information, and the
   // high bits are deliberately dropped (aliasing PCs share a counter).
   assign rd_idx = pc_f[IDX_W+1:2];
   assign wr_idx = pc_d[IDX_W+1:2];

   wire unused_pc_bits = ^{pc_f[31:IDX_W+2], pc_f[1:0],
                           pc_d[31:IDX_W+2], pc_d[1:0]};

   assign is_branch = (nPC_Sel == SEL_BRANCH);

   // A stalled instruction is held in D and updates only on the cycle its
   // stall releases, so it is counted exactly once.
   assign upd = valid_d & ~stall_d & is_branch;

   // No bypass: a same-cycle write to rd_idx is visible only next cycle.
   assign pred_taken_f = table_q[rd_idx][1];

   assign mispredict_d = valid_d & is_branch & (pred_d != bmove);

   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven,
      // so no latch is inferred; it also maps X/Z selects to PC+4.
      PCSrc_D = SRC_PC4;
      case (nPC_Sel)
         SEL_SEQ:    PCSrc_D = SRC_PC4;
         SEL_BRANCH: PCSrc_D = bmove ? SRC_BTGT : SRC_PC4;
         SEL_JIMM:   PCSrc_D = SRC_JIMM;
         SEL_JREG:   PCSrc_D = SRC_JREG;
         default:    PCSrc_D = SRC_PC4;
      endcase
   end

   // Predictor table. Reset forces every entry to weak-not-taken so the
   // first encounter of any branch predicts not-taken but flips after a
   // single taken outcome.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the table is small and must come out of reset in a known
         // weak-NT state, so it is built from flops and reset entry by entry
         // rather than left as an unreset RAM.
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= CNT_WNT;
         end
      end else if (upd) begin
         // NOTE: non-blocking assignment for all sequential state, so the
         // combinational read in this cycle still sees the old value.
         if (bmove) begin
            if (table_q[wr_idx] != CNT_ST) begin
               table_q[wr_idx] <= table_q[wr_idx] + 2'd1;
            end
         end else begin
            if (table_q[wr_idx] != CNT_SNT) begin
               table_q[wr_idx] <= table_q[wr_idx] - 2'd1;
            end
         end
      end
   end

`ifdef BPRED_STATS_EN
   // Saturating statistics counters; they stop at all-ones instead of
   // wrapping so a long run never reports a misleadingly small number.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         br_cnt   <= '0;
         miss_cnt <= '0;
      end else if (upd) begin
         if (br_cnt != {CNT_W{1'b1}}) begin
            br_cnt <= br_cnt + 1'b1;
         end
         if (mispredict_d && (miss_cnt != {CNT_W{1'b1}})) begin
            miss_cnt <= miss_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_pred_unit
//
// Self-checking bench for branch_pred_unit. A behavioural model keeps one
// integer per table slot (0..3, clamped arithmetic) plus integer statistics,
// and every comparison is an immediate assertion against that model or
// against a constant taken from the expected behaviour.
// -----------------------------------------------------------------------------
module tb_branch_pred_unit;

   localparam int IDX_W = 6;
   localparam int CNT_W = 32;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_f;
   logic        pred_taken_f;
   logic        valid_d;
   logic        stall_d;
   logic [31:0] pc_d;
   logic        pred_d;
   logic [1:0]  nPC_Sel;
   logic        bmove;
   logic [1:0]  PCSrc_D;
   logic        mispredict_d;
`ifdef BPRED_STATS_EN
   logic [CNT_W-1:0] br_cnt;
   logic [CNT_W-1:0] miss_cnt;
`endif

   int          model [DEPTH];
   longint      br_m;
   longint      miss_m;
   int          checks;
   int          failures;

   branch_pred_unit #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_f         (pc_f),
      .pred_taken_f (pred_taken_f),
      .valid_d      (valid_d),
      .stall_d      (stall_d),
      .pc_d         (pc_d),
      .pred_d       (pred_d),
      .nPC_Sel      (nPC_Sel),
      .bmove        (bmove),
      .PCSrc_D      (PCSrc_D),
      .mispredict_d (mispredict_d)
`ifdef BPRED_STATS_EN
      ,
      .br_cnt       (br_cnt),
      .miss_cnt     (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic int idx_of(logic [31:0] pc);
      return (pc / 4) % DEPTH;
   endfunction

   function automatic logic [1:0] exp_pcsrc(logic [1:0] sel, logic bm);
      if (sel == 2'd1) return bm ? 2'd1 : 2'd0;
      return sel;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model[i] = 1;
      br_m   = 0;
      miss_m = 0;
   endtask

   // Compare all combinational outputs (and stats) with the model.
   task automatic check_all(string tag);
      check({tag, "_pred"}, 64'(pred_taken_f), 64'(model[idx_of(pc_f)] >= 2));
      check({tag, "_pcsrc"}, 64'(PCSrc_D), 64'(exp_pcsrc(nPC_Sel, bmove)));
      check({tag, "_mis"}, 64'(mispredict_d),
            64'(valid_d && nPC_Sel == 2'd1 && pred_d != bmove));
`ifdef BPRED_STATS_EN
      check({tag, "_br"}, 64'(br_cnt), 64'(br_m));
      check({tag, "_miss"}, 64'(miss_cnt), 64'(miss_m));
`endif
   endtask

   // Advance one clock; apply the resolution rules to the model at the edge.
   task automatic tick();
      bit do_upd;
      bit was_miss;
      int k;
      do_upd   = valid_d && !stall_d && nPC_Sel == 2'd1 && !reset;
      was_miss = valid_d && nPC_Sel == 2'd1 && pred_d != bmove;
      k        = idx_of(pc_d);
      @(posedge clk);
      if (do_upd && !reset) begin
         model[k] = bmove ? ((model[k] < 3) ? model[k] + 1 : 3)
                          : ((model[k] > 0) ? model[k] - 1 : 0);
         br_m++;
         if (was_miss) miss_m++;
      end
      @(negedge clk);
      #1;
   endtask

   task automatic drive(logic [31:0] f, logic [31:0] d, logic [1:0] sel,
                        logic bm, logic pd, logic v, logic st);
      pc_f = f; pc_d = d; nPC_Sel = sel; bmove = bm; pred_d = pd;
      valid_d = v; stall_d = st;
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();
      reset = 1'b1;
      drive(32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset: predictions read 0 even while held in reset.
      check("rst_pred_during", 64'(pred_taken_f), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;

      // Sweep every index: all weak-NT, sequential select.
      for (int i = 0; i < DEPTH; i++) begin
         pc_f = 32'h1000_0000 + 32'(i * 4);
         #1;
         check($sformatf("sweep%0d_pred", i), 64'(pred_taken_f), 64'd0);
      end
      check("sweep_pcsrc", 64'(PCSrc_D), 64'd0);

      // Jumps: select follows nPC_Sel, no misprediction, no table change.
      drive(32'h3000_0020, 32'h3000_0020, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      check("jimm_pcsrc", 64'(PCSrc_D), 64'd2);
      check("jimm_mis", 64'(mispredict_d), 64'd0);
      tick();
      drive(32'h3000_0020, 32'h3000_0020, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      check("jreg_pcsrc", 64'(PCSrc_D), 64'd3);
      check("jreg_mis", 64'(mispredict_d), 64'd0);
      tick();
      drive(32'h3000_0020, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("jump_no_upd", 64'(pred_taken_f), 64'd0);
      check_all("jump");

      // First taken branch at 0x3000_0010 with a not-taken prediction.
      drive(32'h0, 32'h3000_0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("br1_pcsrc", 64'(PCSrc_D), 64'd1);
      check("br1_mis", 64'(mispredict_d), 64'd1);
      tick();
      drive(32'h3000_0010, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("br1_pred_next", 64'(pred_taken_f), 64'd1);
      check_all("br1");

      // Three more taken (saturate at strong-T), then one not-taken.
      for (int i = 0; i < 3; i++) begin
         drive(32'h3000_0010, 32'h3000_0010, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
         check_all($sformatf("sat%0d", i));
         tick();
      end
      drive(32'h3000_0010, 32'h3000_0010, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
      check_all("nt_after_sat");
      check("nt_after_sat_mis", 64'(mispredict_d), 64'd1);
      tick();
      drive(32'h3000_0010, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("sat_then_nt_pred", 64'(pred_taken_f), 64'd1);
      check("sat_model_level", 64'(model[idx_of(32'h3000_0010)]), 64'd2);

      // Stall: three frozen cycles then release -> exactly one update.
      // One update leaves weak-T; a following not-taken must give weak-NT.
      for (int i = 0; i < 3; i++) begin
         drive(32'h3000_0040, 32'h3000_0040, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1);
         check_all($sformatf("stall%0d", i));
         tick();
      end
      drive(32'h3000_0040, 32'h3000_0040, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("stall_pending_pred", 64'(pred_taken_f), 64'd0);
      tick();
      check_all("stall_rel");
      check("stall_rel_pred", 64'(pred_taken_f), 64'd1);
      drive(32'h3000_0040, 32'h3000_0040, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      check("stall_once_pred", 64'(pred_taken_f), 64'd0);
      check_all("stall_once");

      // Same-index read and write in one cycle: no bypass.
      drive(32'h3000_0080, 32'h7000_0080, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("same_idx_now", 64'(pred_taken_f), 64'd0);
      tick();
      check("same_idx_next", 64'(pred_taken_f), 64'd1);
      check_all("same_idx");

      // Reset mid-cycle with an update pending: immediate effect, no write.
      drive(32'h3000_0010, 32'h3000_0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("midrst_pred", 64'(pred_taken_f), 64'd0);
      check("midrst_pcsrc", 64'(PCSrc_D), 64'd1);
      check("midrst_mis", 64'(mispredict_d), 64'd1);
      check_all("midrst");
      tick();
      reset = 1'b0;
      drive(32'h3000_0010, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("post_rst_pred", 64'(pred_taken_f), 64'd0);
      check_all("post_rst");

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] f;
         logic [31:0] d;
         f = $urandom;
         d = $urandom;
         if ($urandom_range(0, 1) == 0) d[IDX_W+1:2] = f[IDX_W+1:2];
         drive(f, d, 2'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 1'($urandom_range(0, 7) != 0),
               1'($urandom_range(0, 3) == 0));
         check_all($sformatf("rnd%0d", n));
         tick();
      end
      check_all("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound so the bench cannot hang.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
